// File: rtl/rename_unit_pkg.sv
// Shared constants and helpers for the register-rename stage.
package rename_pkg;

   localparam int ARCH_W = 5;

   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // An instruction writes a register only if rd is not x0 and it is not a store/branch
   // (those encodings reuse the rd field for immediate bits).
   function automatic logic needs_rd(input logic [6:0] opcode, input logic [ARCH_W-1:0] rd);
      return (rd != '0) && (opcode != OPC_STORE) && (opcode != OPC_BRANCH);
   endfunction

endpackage

// File: rtl/rename_unit_preg_find_first.sv
// Priority encoder: index of the lowest set bit of req_i, plus a found flag.
module preg_find_first #(
   parameter int N = 64,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rename_unit.sv
// Register-rename stage: speculative RAT, busy-bit free pool, retirement RAT
// for flush recovery, one registered output stage with valid/ready.
module rename_unit
   import rename_pkg::*;
#(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64,
   parameter int PREG_W    = $clog2(PHYS_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   // decode side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_instr,
   // dispatch side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_opcode,
   output logic [31:0]       out_instr,
   output logic [PREG_W-1:0] out_ps1,
   output logic [PREG_W-1:0] out_ps2,
   output logic [PREG_W-1:0] out_pd,
   output logic [PREG_W-1:0] out_old_pd,
   output logic              out_has_rd,
   // retirement
   input  logic              commit_valid,
   input  logic [4:0]        commit_rd,
   input  logic [PREG_W-1:0] commit_pd,
   input  logic [PREG_W-1:0] commit_old_pd,
   input  logic              flush,
   output logic [PREG_W:0]   free_count
);

   // P0..P(ARCH_REGS-1) hold the identity mapping out of reset.
   localparam logic [PHYS_REGS-1:0] RESET_BUSY =
      {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

   logic [PREG_W-1:0]    rat_q  [ARCH_REGS];
   logic [PREG_W-1:0]    rat_d  [ARCH_REGS];
   logic [PREG_W-1:0]    rrat_q [ARCH_REGS];
   logic [PREG_W-1:0]    rrat_d [ARCH_REGS];
   logic [PHYS_REGS-1:0] busy_q, busy_d;
   logic [PHYS_REGS-1:0] arch_busy_q, arch_busy_d;

   logic                 out_valid_q;
   logic [6:0]           out_opcode_q;
   logic [31:0]          out_instr_q;
   logic [PREG_W-1:0]    out_ps1_q, out_ps2_q, out_pd_q, out_old_pd_q;
   logic                 out_has_rd_q;

   logic                 rd_needed;
   logic                 accept;
   logic                 commit_en;
   logic [PREG_W-1:0]    alloc_pd;
   logic                 alloc_found;
   logic [PHYS_REGS-1:0] free_vec;

   // P0 is excluded from allocation even though it is permanently busy anyway.
   assign free_vec = {~busy_q[PHYS_REGS-1:1], 1'b0};

   preg_find_first #(
      .N (PHYS_REGS),
      .W (PREG_W)
   ) u_find (
      .req_i   (free_vec),
      .idx_o   (alloc_pd),
      .found_o (alloc_found)
   );

   assign rd_needed = needs_rd(in_opcode, in_rd);
   assign in_ready  = (!out_valid_q || out_ready) && !flush && (alloc_found || !rd_needed);
   assign accept    = in_valid && in_ready;
   assign commit_en = commit_valid && (commit_rd != '0);

   // Population count of free physical registers, always consistent with busy_q.
   always_comb begin
      free_count = '0;
      for (int i = 0; i < PHYS_REGS; i++) begin
         free_count = free_count + (PREG_W + 1)'(!busy_q[i]);
      end
   end

   // Next-state of the mapping tables: commit first, then either flush-restore or rename.
   always_comb begin
      rat_d       = rat_q;
      rrat_d      = rrat_q;
      busy_d      = busy_q;
      arch_busy_d = arch_busy_q;

      if (commit_en) begin
         rrat_d[commit_rd] = commit_pd;
         if (commit_old_pd != '0) begin
            arch_busy_d[commit_old_pd] = 1'b0;
            busy_d[commit_old_pd]      = 1'b0;
         end
         arch_busy_d[commit_pd] = 1'b1;
      end

      if (flush) begin
         // Flush restores from the post-commit retirement state.
         rat_d  = rrat_d;
         busy_d = arch_busy_d;
      end else if (accept && rd_needed) begin
         // alloc_pd comes from pre-commit busy_q, so a register freed this
         // cycle can only be handed out next cycle.
         rat_d[in_rd]     = alloc_pd;
         busy_d[alloc_pd] = 1'b1;
      end
   end

   // Mapping table state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            rat_q[i]  <= PREG_W'(i);
            rrat_q[i] <= PREG_W'(i);
         end
         busy_q      <= RESET_BUSY;
         arch_busy_q <= RESET_BUSY;
      end else begin
         rat_q       <= rat_d;
         rrat_q      <= rrat_d;
         busy_q      <= busy_d;
         arch_busy_q <= arch_busy_d;
      end
   end

   // Output stage: load on accept, drop on transfer or flush, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_instr_q  <= '0;
         out_ps1_q    <= '0;
         out_ps2_q    <= '0;
         out_pd_q     <= '0;
         out_old_pd_q <= '0;
         out_has_rd_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         out_opcode_q <= in_opcode;
         out_instr_q  <= in_instr;
         out_ps1_q    <= rat_q[in_rs1];
         out_ps2_q    <= rat_q[in_rs2];
         out_pd_q     <= rd_needed ? alloc_pd : '0;
         out_old_pd_q <= rd_needed ? rat_q[in_rd] : '0;
         out_has_rd_q <= rd_needed;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_opcode = out_opcode_q;
   assign out_instr  = out_instr_q;
   assign out_ps1    = out_ps1_q;
   assign out_ps2    = out_ps2_q;
   assign out_pd     = out_pd_q;
   assign out_old_pd = out_old_pd_q;
   assign out_has_rd = out_has_rd_q;

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: stimulus pushes expected renames, a
// negedge monitor pops and compares on every output transfer.
module tb_rename_unit;

   localparam int PW = 6;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [6:0]    in_opcode = '0;
   logic [4:0]    in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic [31:0]   in_instr = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [6:0]    out_opcode;
   logic [31:0]   out_instr;
   logic [PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd;
   logic          out_has_rd;
   logic          commit_valid = 1'b0;
   logic [4:0]    commit_rd = '0;
   logic [PW-1:0] commit_pd = '0, commit_old_pd = '0;
   logic          flush = 1'b0;
   logic [PW:0]   free_count;

   rename_unit dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_instr(out_instr), .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd),
      .out_old_pd(out_old_pd), .out_has_rd(out_has_rd),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd),
      .commit_old_pd(commit_old_pd), .flush(flush), .free_count(free_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]    op;
      logic [31:0]   instr;
      logic [PW-1:0] ps1, ps2, pd, old;
      logic          has;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   // Monitor: one scoreboard entry consumed per output transfer.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total_cnt++;
         if (sb_q.size() == 0) begin
            $display("FAIL xfer_unexpected actual pd=%0d required=no transfer", out_pd);
         end else begin
            mon_e = sb_q.pop_front();
            if (out_opcode === mon_e.op && out_instr === mon_e.instr && out_ps1 === mon_e.ps1 &&
                out_ps2 === mon_e.ps2 && out_pd === mon_e.pd && out_old_pd === mon_e.old &&
                out_has_rd === mon_e.has) begin
               pass_cnt++;
               $display("xfer op=%b ps1=%0d ps2=%0d pd=%0d old_pd=%0d has_rd=%0d",
                        out_opcode, out_ps1, out_ps2, out_pd, out_old_pd, out_has_rd);
            end else begin
               $display("FAIL xfer actual ps1=%0d ps2=%0d pd=%0d old=%0d has=%0d op=%b instr=%h required ps1=%0d ps2=%0d pd=%0d old=%0d has=%0d op=%b instr=%h",
                        out_ps1, out_ps2, out_pd, out_old_pd, out_has_rd, out_opcode, out_instr,
                        mon_e.ps1, mon_e.ps2, mon_e.pd, mon_e.old, mon_e.has, mon_e.op, mon_e.instr);
            end
         end
      end
   end

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rs1, rs2, rd);
      return {7'h15, rs2, rs1, 3'b010, rd, op};
   endfunction

   task automatic set_in(input logic [6:0] op, input logic [4:0] rs1, rs2, rd);
      in_opcode = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_instr  = enc(op, rs1, rs2, rd);
   endtask

   // Present one instruction, wait (bounded) for acceptance, push its expected rename.
   task automatic issue(input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                        input int e_ps1, e_ps2, e_pd, e_old, input logic e_has,
                        output int waited);
      exp_t e;
      set_in(op, rs1, rs2, rd);
      in_valid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            total_cnt++;
            $display("FAIL accept_timeout actual=no accept required=accept rd=%0d", rd);
            in_valid = 1'b0;
            return;
         end
      end
      e.op = op; e.instr = in_instr; e.ps1 = PW'(e_ps1); e.ps2 = PW'(e_ps2);
      e.pd = PW'(e_pd); e.old = PW'(e_old); e.has = e_has;
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      chk("drained_before_reset", sb_q.size(), 0);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; commit_valid = 1'b0; out_ready = 1'b1;
      set_in(OP_I, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // ---- reset state + single rename
      do_reset();
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_pd", out_pd, 0);
      chk("reset_free_count", free_count, 32);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;
      issue(OP_R, 1, 2, 5, 1, 2, 32, 5, 1, w);
      chk("add_free_count", free_count, 31);

      // ---- back-to-back dependency
      @(posedge clk); #1; do_reset();
      issue(OP_I, 0, 1, 5, 0, 1, 32, 5, 1, w);
      issue(OP_R, 5, 5, 6, 32, 32, 33, 6, 1, w);
      chk("b2b_wait", w, 0);

      // ---- no-destination instructions
      @(posedge clk); #1; do_reset();
      issue(OP_SW, 1, 2, 4, 1, 2, 0, 0, 0, w);
      issue(OP_BR, 3, 4, 8, 3, 4, 0, 0, 0, w);
      issue(OP_R, 1, 2, 0, 1, 2, 0, 0, 0, w);
      chk("nodest_free_count", free_count, 32);

      // ---- exhaust the free pool
      @(posedge clk); #1; do_reset();
      for (int i = 0; i < 32; i++) begin
         issue(OP_I, 0, 0, (i < 31) ? 5'(i + 1) : 5'd1, 0, 0, 32 + i, (i < 31) ? i + 1 : 32, 1, w);
      end
      chk("full_free_count", free_count, 0);
      set_in(OP_R, 1, 2, 7);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      issue(OP_SW, 1, 2, 0, 63, 33, 0, 0, 0, w);
      chk("full_store_wait", w, 0);
      commit_valid = 1'b1; commit_rd = 5; commit_pd = 36; commit_old_pd = 5;
      set_in(OP_R, 1, 2, 7);
      in_valid = 1'b1;
      @(negedge clk);
      chk("commit_cycle_in_ready", in_ready, 0);
      chk("commit_cycle_free", free_count, 0);
      @(posedge clk); #1;
      commit_valid = 1'b0;
      chk("after_commit_free", free_count, 1);
      issue(OP_R, 1, 2, 7, 63, 33, 5, 38, 1, w);
      chk("realloc_wait", w, 0);
      chk("realloc_free", free_count, 0);

      // ---- commit + flush in the same cycle
      @(posedge clk); #1; do_reset();
      issue(OP_R, 1, 2, 5, 1, 2, 32, 5, 1, w);
      issue(OP_R, 1, 2, 6, 1, 2, 33, 6, 1, w);
      issue(OP_R, 1, 2, 7, 1, 2, 34, 7, 1, w);
      commit_valid = 1'b1; commit_rd = 5; commit_pd = 32; commit_old_pd = 5;
      flush = 1'b1;
      set_in(OP_R, 1, 2, 9);
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      commit_valid = 1'b0; flush = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_free_count", free_count, 32);
      issue(OP_R, 5, 6, 8, 32, 6, 5, 8, 1, w);

      // ---- output back-pressure
      @(posedge clk); #1; do_reset();
      out_ready = 1'b0;
      issue(OP_R, 1, 2, 5, 1, 2, 32, 5, 1, w);
      set_in(OP_R, 3, 4, 6);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_pd", out_pd, 32);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_free", free_count, 31);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      issue(OP_R, 3, 4, 6, 3, 4, 33, 6, 1, w);
      chk("release_wait1", w, 0);
      issue(OP_R, 6, 5, 7, 33, 32, 34, 7, 1, w);
      chk("release_wait2", w, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("final_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
